// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM state encodings and port identifiers.
package dmem_arbiter_pkg;

    typedef logic [1:0] state_t;

    // One transaction at a time: accept, drive the memory, return the response.
    localparam state_t StIdle   = 2'd0;
    localparam state_t StAccess = 2'd1;
    localparam state_t StResp   = 2'd2;

    // Port identifiers double as the grant / last-grant encoding.
    localparam logic PortCpu = 1'b0;
    localparam logic PortDbg = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way arbiter: round-robin on last grant, or fixed priority for port 0.
module dmem_arbiter_rr
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    input  logic       fixed_prio_i,
    output logic       grant_o,
    output logic       grant_valid_o
);

    // Contention goes to the port not served last unless port 0 is pinned as winner.
    always_comb begin
        grant_valid_o = |req_i;
        if (&req_i && !fixed_prio_i) begin
            grant_o = ~last_grant_i;
        end else if (req_i[0]) begin
            grant_o = PortCpu;
        end else begin
            grant_o = PortDbg;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory (1-cycle registered read, single-cycle write) between
// the CPU load/store port (0) and the debug/DMA port (1). Three cycles per transaction.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0Valid,
    input  logic                  req0Write,
    input  logic [ADDR_WIDTH-1:0] req0Addr,
    input  logic [DATA_WIDTH-1:0] req0Data,
    output logic                  req0Ready,
    output logic                  rsp0Valid,
    output logic [DATA_WIDTH-1:0] rsp0Data,
    output logic                  rsp0Err,
    input  logic                  req1Valid,
    input  logic                  req1Write,
    input  logic [ADDR_WIDTH-1:0] req1Addr,
    input  logic [DATA_WIDTH-1:0] req1Data,
    output logic                  req1Ready,
    output logic                  rsp1Valid,
    output logic [DATA_WIDTH-1:0] rsp1Data,
    output logic                  rsp1Err,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memDataIn,
    input  logic [DATA_WIDTH-1:0] memDataOut,
    output logic                  memEnable,
    output logic                  memReadNotWrite
);

    // Full-width compare: addresses beyond the array never alias into it.
    localparam logic [ADDR_WIDTH-1:0] MemLimit = ADDR_WIDTH'(MEM_WORDS);

    state_t                state_q, state_d;
    logic                  port_q, port_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic                  last_grant_q, last_grant_d;

    logic grant;
    logic grant_valid;
    logic in_range;
    logic accept;

    dmem_arbiter_rr u_rr (
        .req_i         ({req1Valid, req0Valid}),
        .last_grant_i  (last_grant_q),
        .fixed_prio_i  (FIXED_PRIO != 0),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    assign in_range = (addr_q < MemLimit);
    assign accept   = req0Ready | req1Ready;

    // Next-state: latch the granted request in IDLE, record the range error in ACCESS.
    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        write_d      = write_q;
        addr_d       = addr_q;
        data_d       = data_q;
        err_d        = err_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    port_d       = grant;
                    write_d      = (grant == PortDbg) ? req1Write : req0Write;
                    addr_d       = (grant == PortDbg) ? req1Addr : req0Addr;
                    data_d       = (grant == PortDbg) ? req1Data : req0Data;
                    err_d        = 1'b0;
                    last_grant_d = grant;
                    state_d      = StAccess;
                end
            end
            StAccess: begin
                err_d   = ~in_range;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset leaves port 1 as last grant so port 0 wins first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            port_q       <= PortCpu;
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            last_grant_q <= PortDbg;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs are gated by reset so a held reset never writes memory or handshakes.
    always_comb begin
        req0Ready       = 1'b0;
        req1Ready       = 1'b0;
        rsp0Valid       = 1'b0;
        rsp1Valid       = 1'b0;
        rsp0Data        = '0;
        rsp1Data        = '0;
        rsp0Err         = 1'b0;
        rsp1Err         = 1'b0;
        memAddr         = '0;
        memDataIn       = '0;
        memEnable       = 1'b0;
        memReadNotWrite = 1'b1;
        if (!reset) begin
            case (state_q)
                StIdle: begin
                    req0Ready = grant_valid && (grant == PortCpu) && req0Valid;
                    req1Ready = grant_valid && (grant == PortDbg) && req1Valid;
                end
                StAccess: begin
                    memAddr   = addr_q;
                    memDataIn = data_q;
                    if (in_range) begin
                        memEnable       = 1'b1;
                        memReadNotWrite = ~write_q;
                    end
                end
                StResp: begin
                    if (port_q == PortDbg) begin
                        rsp1Valid = 1'b1;
                        rsp1Data  = (!write_q && !err_q) ? memDataOut : '0;
                        rsp1Err   = err_q;
                    end else begin
                        rsp0Valid = 1'b1;
                        rsp0Data  = (!write_q && !err_q) ? memDataOut : '0;
                        rsp0Err   = err_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, scoreboard on responses, and corner-case sequences.
module tb_dmem_arbiter;

    localparam int MW = 1024;
    localparam logic [31:0] MwL = 32'd1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_clear;
    logic        req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
    logic        req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
    logic [31:0] req0_addr, req0_data, rsp0_data, req1_addr, req1_data, rsp1_data;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_en, mem_rnw;

    logic        fp_req0_valid, fp_req1_valid, fp_req0_ready, fp_req1_ready;
    logic        fp_rsp0_valid, fp_rsp1_valid, fp_rsp0_err, fp_rsp1_err;
    logic [31:0] fp_rsp0_data, fp_rsp1_data, fp_mem_addr, fp_mem_din;
    logic        fp_mem_en, fp_mem_rnw;
    logic [31:0] fp_mem_dout = 32'h0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .req0Valid(req0_valid), .req0Write(req0_write), .req0Addr(req0_addr),
        .req0Data(req0_data), .req0Ready(req0_ready),
        .rsp0Valid(rsp0_valid), .rsp0Data(rsp0_data), .rsp0Err(rsp0_err),
        .req1Valid(req1_valid), .req1Write(req1_write), .req1Addr(req1_addr),
        .req1Data(req1_data), .req1Ready(req1_ready),
        .rsp1Valid(rsp1_valid), .rsp1Data(rsp1_data), .rsp1Err(rsp1_err),
        .memAddr(mem_addr), .memDataIn(mem_din), .memDataOut(mem_dout),
        .memEnable(mem_en), .memReadNotWrite(mem_rnw)
    );

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .req0Valid(fp_req0_valid), .req0Write(1'b0), .req0Addr(32'd3),
        .req0Data(32'h0), .req0Ready(fp_req0_ready),
        .rsp0Valid(fp_rsp0_valid), .rsp0Data(fp_rsp0_data), .rsp0Err(fp_rsp0_err),
        .req1Valid(fp_req1_valid), .req1Write(1'b0), .req1Addr(32'd4),
        .req1Data(32'h0), .req1Ready(fp_req1_ready),
        .rsp1Valid(fp_rsp1_valid), .rsp1Data(fp_rsp1_data), .rsp1Err(fp_rsp1_err),
        .memAddr(fp_mem_addr), .memDataIn(fp_mem_din), .memDataOut(fp_mem_dout),
        .memEnable(fp_mem_en), .memReadNotWrite(fp_mem_rnw)
    );

    // Memory model: registered read, write whenever readNotWrite is low.
    logic [31:0] mem [MW];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < MW; i++) mem[i] <= 32'h0;
        end else if (!mem_rnw && mem_addr < MwL) begin
            mem[mem_addr[9:0]] <= mem_din;
        end
        if (mem_en && mem_addr < MwL) mem_dout <= mem[mem_addr[9:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          grant_log[$];
    int          fp_acc0 = 0;
    int          fp_acc1 = 0;
    logic [31:0] ref_mem [MW];

    task automatic score_req(input int port, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata);
        exp_t x;
        x.addr  = addr;
        x.wdata = wdata;
        x.wr    = wr;
        x.err   = (addr >= MwL);
        x.data  = (!wr && !x.err) ? ref_mem[addr[9:0]] : 32'h0;
        x.due   = cyc + 2;
        if (port == 0) q0.push_back(x);
        else q1.push_back(x);
        grant_log.push_back(port);
    endtask

    task automatic score_rsp(input int port, input logic [31:0] d, input logic e);
        exp_t x;
        if ((port == 0 && q0.size() == 0) || (port == 1 && q1.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp port %0d: got a response, want none (cycle %0d)",
                     port, cyc);
            return;
        end
        x = (port == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("rsp%0d_data", port), d, x.data);
        check($sformatf("rsp%0d_err", port), 32'(e), 32'(x.err));
        check($sformatf("rsp%0d_latency", port), cyc, x.due);
        if (x.wr && !x.err) ref_mem[x.addr[9:0]] = x.wdata;
    endtask

    // Monitor: invariants, accept -> expectation push, response -> pop and compare.
    always @(negedge clk) begin
        cyc++;
        if (mem_clear) for (int i = 0; i < MW; i++) ref_mem[i] = 32'h0;
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            check("ready_onehot", 32'(req0_ready & req1_ready), 0);
            check("write_only_when_enabled", 32'(!mem_rnw && !mem_en), 0);
            check("enable_in_range", 32'(mem_en && mem_addr >= MwL), 0);
            if (fp_mem_en) check("fp_enable_in_range", 32'(fp_mem_addr >= MwL), 0);
            check("fp_write_never", 32'(!fp_mem_rnw), 0);
            if (rsp0_valid) score_rsp(0, rsp0_data, rsp0_err);
            if (rsp1_valid) score_rsp(1, rsp1_data, rsp1_err);
            if (req0_ready && req0_valid) score_req(0, req0_write, req0_addr, req0_data);
            if (req1_ready && req1_valid) score_req(1, req1_write, req1_addr, req1_data);
            if (fp_req0_ready) fp_acc0++;
            if (fp_req1_ready) fp_acc1++;
            if (fp_rsp0_valid || fp_rsp1_valid) begin
                check("fp_rsp_word", fp_rsp0_data | fp_rsp1_data | fp_mem_din, 0);
                check("fp_rsp_err", 32'(fp_rsp0_err | fp_rsp1_err), 0);
            end
        end
    end

    task automatic do_req(input int port, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] rd, output logic re);
        bit ok;
        ok = 1'b0;
        rd = 32'h0;
        re = 1'b0;
        @(posedge clk);
        #1;
        if (port == 0) begin
            req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_data = data;
        end else begin
            req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_data = data;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = (port == 0) ? req0_ready : req1_ready;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout port %0d: got no ready, want ready in 20 cycles", port);
            return;
        end
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (port == 0 && rsp0_valid) begin
                ok = 1'b1; rd = rsp0_data; re = rsp0_err;
            end else if (port == 1 && rsp1_valid) begin
                ok = 1'b1; rd = rsp1_data; re = rsp1_err;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL rsp_timeout port %0d: got no response, want one in 10 cycles", port);
        end
    endtask

    typedef struct {
        int          port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[11];
    logic [31:0] rd;
    logic        re;
    int          n;
    bit          ok;

    initial begin
        vecs[0]  = '{0, 1'b1, 32'd5,          32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{0, 1'b0, 32'd5,          32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1, 1'b1, 32'd1023,       32'hA5A50001, 32'h0,        1'b0};
        vecs[3]  = '{1, 1'b0, 32'd1023,       32'h0,        32'hA5A50001, 1'b0};
        vecs[4]  = '{1, 1'b0, 32'd1024,       32'h0,        32'h0,        1'b1};
        vecs[5]  = '{0, 1'b1, 32'hFFFFFFFF,   32'h00001234, 32'h0,        1'b1};
        vecs[6]  = '{0, 1'b0, 32'd5,          32'h0,        32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1, 1'b1, 32'd0,          32'hCAFEF00D, 32'h0,        1'b0};
        vecs[8]  = '{0, 1'b0, 32'd0,          32'h0,        32'hCAFEF00D, 1'b0};
        vecs[9]  = '{0, 1'b1, 32'h00010005,   32'h11111111, 32'h0,        1'b1};
        vecs[10] = '{1, 1'b0, 32'd5,          32'h0,        32'hDEADBEEF, 1'b0};

        reset = 1'b1; mem_clear = 1'b1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 32'h0; req0_data = 32'h0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 32'h0; req1_data = 32'h0;
        fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rnw", 32'(mem_rnw), 1);
        check("reset_enable", 32'(mem_en), 0);
        check("reset_addr", mem_addr, 0);
        check("reset_din", mem_din, 0);
        check("reset_strobes", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid}), 0);
        check("reset_rsp_data", rsp0_data | rsp1_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b0; mem_clear = 1'b0;

        // Idle with no requests: memory bus quiet and contents unchanged.
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (!mem_rnw || mem_en) n++;
        end
        check("idle_bus_quiet_cycles", n, 0);
        n = 0;
        for (int i = 0; i < MW; i++) if (mem[i] !== 32'h0) n++;
        check("idle_mem_unchanged", n, 0);

        for (int i = 0; i < 11; i++) begin
            do_req(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].data, rd, re);
            check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), 32'(re), 32'(vecs[i].exp_err));
        end
        check("mem_word5", mem[5], 32'hDEADBEEF);

        // Round-robin: both ports hold loads; grants alternate, 8 transactions in 24 cycles.
        @(posedge clk);
        #1;
        req0_write = 1'b0; req0_addr = 32'd5; req0_valid = 1'b1;
        req1_write = 1'b0; req1_addr = 32'd0; req1_valid = 1'b1;
        grant_log.delete();
        repeat (24) @(negedge clk);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rr_grant_count", grant_log.size(), 8);
        n = 0;
        for (int i = 0; i < grant_log.size(); i++) if (grant_log[i] == 0) n++;
        check("rr_port0_grants", n, 4);
        for (int i = 1; i < grant_log.size(); i++)
            check($sformatf("rr_alternate%0d", i), 32'(grant_log[i] != grant_log[i-1]), 1);

        // Fixed priority: port 1 starves while port 0 holds valid, then gets served.
        @(posedge clk);
        #1;
        fp_req0_valid = 1'b1; fp_req1_valid = 1'b1;
        fp_acc0 = 0; fp_acc1 = 0;
        repeat (30) @(negedge clk);
        check("fp_port1_grants", fp_acc1, 0);
        check("fp_port0_grants", fp_acc0, 10);
        @(posedge clk);
        #1;
        fp_req0_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            @(negedge clk);
            ok = fp_req1_ready;
        end
        check("fp_port1_after_release", 32'(ok), 1);
        @(posedge clk);
        #1;
        fp_req1_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during the ACCESS cycle of a store: no write, no response, port 0 first after.
        @(posedge clk);
        #1;
        req0_write = 1'b1; req0_addr = 32'd7; req0_data = 32'h77777777; req0_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = req0_ready;
        end
        check("rst_store_accepted", 32'(ok), 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_access_rnw", 32'(mem_rnw), 1);
        check("rst_access_enable", 32'(mem_en), 0);
        @(posedge clk);
        #1;
        req0_write = 1'b0; req0_addr = 32'd7; req0_valid = 1'b1;
        req1_write = 1'b0; req1_addr = 32'd1; req1_valid = 1'b1;
        @(negedge clk);
        check("rst_ready_gated", 32'({req0_ready, req1_ready, rsp0_valid}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        grant_log.delete();
        @(negedge clk);
        check("rst_port0_first", 32'(req0_ready), 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = req1_ready;
        end
        check("rst_port1_next", 32'(ok), 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_store_dropped", mem[7], 32'h0);
        check("rst_grant_order", grant_log.size() > 0 ? grant_log[0] : 9, 0);
        check("scoreboard_drained", q0.size() + q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, want finish before 100000 ns");
        $fatal(1, "watchdog");
    end

endmodule
